// File: rtl/riscv_mcsr_responder.sv
// Machine-mode trap CSR file (mstatus, mtvec, mscratch, mepc, mcause) answering
// CSR requests over valid/ready with a one-cycle registered response.
module riscv_mcsr_responder #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0080,
   parameter bit          MEPC_LSB0 = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_req_valid_i,
   output logic        csr_req_ready_o,
   input  logic [11:0] csr_addr_i,
   input  logic [1:0]  csr_op_i,
   input  logic [31:0] csr_wdata_i,
   input  logic        csr_we_i,
   output logic        csr_rsp_valid_o,
   input  logic        csr_rsp_ready_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_illegal_o,
   input  logic        trap_i,
   input  logic [31:0] trap_pc_i,
   input  logic [5:0]  trap_cause_i,
   input  logic        mret_i,
   output logic [31:0] mepc_o,
   output logic [31:0] mtvec_o,
   output logic        mie_o
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;

   typedef enum logic {IDLE, RESP} state_t;
   state_t state;

   logic        mie, mpie;
   logic [31:0] mtvec, mscratch, mepc, mcause;
   logic        legal, accept, wr;
   logic [31:0] old, wval;

   function automatic logic [31:0] mepc_fix(input logic [31:0] v);
      return {v[31:1], MEPC_LSB0 ? 1'b0 : v[0]};
   endfunction

   always_comb begin
      legal = 1'b1;
      old   = '0;
      case (csr_addr_i)
         A_MSTATUS:  old = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
         A_MTVEC:    old = mtvec;
         A_MSCRATCH: old = mscratch;
         A_MEPC:     old = mepc;
         A_MCAUSE:   old = mcause;
         default:    legal = 1'b0;
      endcase
      case (csr_op_i)
         2'b10:   wval = old | csr_wdata_i;
         2'b11:   wval = old & ~csr_wdata_i;
         default: wval = csr_wdata_i;
      endcase
   end

   assign accept  = csr_req_valid_i & csr_req_ready_o;
   // a plain read (op 00) never writes, even with we set
   assign wr      = accept & csr_we_i & legal & (csr_op_i != 2'b00);
   assign mepc_o  = mepc;
   assign mtvec_o = mtvec;
   assign mie_o   = mie;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         csr_req_ready_o <= 1'b1;
         csr_rsp_valid_o <= 1'b0;
         csr_rdata_o     <= '0;
         csr_illegal_o   <= 1'b0;
         mie             <= 1'b0;
         mpie            <= 1'b0;
         mtvec           <= {MTVEC_RST[31:2], 2'b00};
         mscratch        <= '0;
         mepc            <= '0;
         mcause          <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state           <= RESP;
               csr_req_ready_o <= 1'b0;
               csr_rsp_valid_o <= 1'b1;
               csr_rdata_o     <= legal ? old : 32'h0;
               csr_illegal_o   <= ~legal;
            end
            RESP: if (csr_rsp_ready_i) begin
               state           <= IDLE;
               csr_req_ready_o <= 1'b1;
               csr_rsp_valid_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         if (wr && csr_addr_i == A_MTVEC)    mtvec    <= wval;
         if (wr && csr_addr_i == A_MSCRATCH) mscratch <= wval;

         // trap owns mepc/mcause/mstatus this cycle; mret owns mstatus
         if (trap_i) begin
            mepc   <= mepc_fix(trap_pc_i);
            mcause <= {trap_cause_i[5], 26'b0, trap_cause_i[4:0]};
            mpie   <= mie;
            mie    <= 1'b0;
         end else begin
            if (wr && csr_addr_i == A_MEPC)   mepc   <= mepc_fix(wval);
            if (wr && csr_addr_i == A_MCAUSE) mcause <= {wval[31], 26'b0, wval[4:0]};
            if (mret_i) begin
               mie  <= mpie;
               mpie <= 1'b1;
            end else if (wr && csr_addr_i == A_MSTATUS) begin
               mie  <= wval[3];
               mpie <= wval[7];
            end
         end
      end
   end
endmodule

// File: tb/tb_riscv_mcsr_responder.sv
// Directed and randomized checks of riscv_mcsr_responder against a table-based
// model of the five CSRs (values held in their architectural read form).
module tb_riscv_mcsr_responder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, we, rsp_valid, rsp_ready, illegal;
   logic        trap, mret, mie;
   logic [11:0] addr;
   logic [1:0]  op;
   logic [31:0] wdata, rdata, trap_pc, mepc, mtvec;
   logic [5:0]  cause;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   riscv_mcsr_responder dut (
      .clk(clk), .rst_n(rst_n),
      .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
      .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i(wdata), .csr_we_i(we),
      .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
      .csr_rdata_o(rdata), .csr_illegal_o(illegal),
      .trap_i(trap), .trap_pc_i(trap_pc), .trap_cause_i(cause), .mret_i(mret),
      .mepc_o(mepc), .mtvec_o(mtvec), .mie_o(mie)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---- reference model: index 0..4 = mstatus, mtvec, mscratch, mepc, mcause
   logic [31:0] m_csr [5];
   logic        e_valid, e_ill;
   logic [31:0] e_rdata;

   function automatic int idx(input logic [11:0] a);
      case (a)
         12'h300: return 0;
         12'h305: return 1;
         12'h340: return 2;
         12'h341: return 3;
         12'h342: return 4;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] norm(input int i, input logic [31:0] v);
      case (i)
         0:       return (v & 32'h88) | 32'h1800;
         3:       return v & ~32'h1;
         4:       return v & 32'h8000_001F;
         default: return v;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [31:0] nx [5];
      logic [31:0] res;
      int i;
      if (!rst_n) begin
         m_csr[0] <= 32'h1800; m_csr[1] <= 32'h80; m_csr[2] <= 0;
         m_csr[3] <= 0;        m_csr[4] <= 0;
         e_valid <= 1'b0; e_rdata <= 0; e_ill <= 1'b0;
      end else begin
         for (int k = 0; k < 5; k++) nx[k] = m_csr[k];
         i = idx(addr);
         if (e_valid && rsp_ready) e_valid <= 1'b0;
         if (req_valid && !e_valid) begin
            e_valid <= 1'b1;
            e_rdata <= (i >= 0) ? m_csr[i] : 32'h0;
            e_ill   <= (i < 0);
            if (we && i >= 0 && op != 2'b00) begin
               res = (op == 2'b01) ? wdata :
                     (op == 2'b10) ? (m_csr[i] | wdata) : (m_csr[i] & ~wdata);
               nx[i] = norm(i, res);
            end
         end
         if (trap) begin
            nx[3] = trap_pc & ~32'h1;
            nx[4] = {cause[5], 26'b0, cause[4:0]};
            nx[0] = 32'h1800 | (m_csr[0][3] ? 32'h80 : 32'h0);
         end else if (mret) begin
            nx[0] = 32'h1880 | (m_csr[0][7] ? 32'h8 : 32'h0);
         end
         for (int k = 0; k < 5; k++) m_csr[k] <= nx[k];
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("m_req_ready", {31'b0, req_ready}, {31'b0, ~e_valid});
         chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
         chk("m_rdata", rdata, e_rdata);
         chk("m_illegal", {31'b0, illegal}, {31'b0, e_ill});
         chk("m_mepc", mepc, m_csr[3]);
         chk("m_mtvec", mtvec, m_csr[1]);
         chk("m_mie", {31'b0, mie}, {31'b0, m_csr[0][3]});
      end
   end

   // ---- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req_valid = 0; addr = 0; op = 0; wdata = 0; we = 0; rsp_ready = 1;
      trap = 0; trap_pc = 0; cause = 0; mret = 0;
   endtask

   // issue one request; on return the response is showing (accept edge + 1)
   task automatic issue(input logic [11:0] a, input logic [1:0] o,
                        input logic [31:0] d, input logic w);
      req_valid = 1; addr = a; op = o; wdata = d; we = w;
      tick();
      req_valid = 0; we = 0;
   endtask

   initial begin
      idle_in();
      rst_n = 0;
      repeat (3) tick();
      chk("rst_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mtvec", mtvec, 32'h80);
      rst_n = 1;
      check_en = 1;
      tick();

      issue(12'h305, 2'b00, 0, 0);
      chk("rd_mtvec", rdata, 32'h80);
      chk("rd_mtvec_valid", {31'b0, rsp_valid}, 32'h1);
      tick();
      issue(12'h341, 2'b00, 0, 0);
      chk("rd_mepc", rdata, 32'h0);
      tick();
      issue(12'h341, 2'b01, 32'h1235, 1);
      chk("wr_mepc_old", rdata, 32'h0);
      chk("wr_mepc_val", mepc, 32'h1234);
      tick();
      issue(12'h341, 2'b01, 32'h5678, 0);
      chk("wr_mepc_we0", mepc, 32'h1234);
      tick();
      issue(12'h300, 2'b10, 32'h8, 1);
      chk("set_mie_old", rdata, 32'h1800);
      chk("set_mie", {31'b0, mie}, 32'h1);
      tick();
      trap = 1; trap_pc = 32'h400; cause = 6'h0B;
      tick();
      trap = 0;
      chk("trap_mepc", mepc, 32'h400);
      chk("trap_mie", {31'b0, mie}, 32'h0);
      issue(12'h342, 2'b00, 0, 0);
      chk("trap_mcause", rdata, 32'hB);
      tick();
      issue(12'h300, 2'b00, 0, 0);
      chk("trap_mstatus", rdata, 32'h1880);
      tick();
      mret = 1;
      tick();
      mret = 0;
      chk("mret_mie", {31'b0, mie}, 32'h1);
      // write to mepc collides with a trap
      trap = 1; trap_pc = 32'h800; cause = 6'h22;
      issue(12'h341, 2'b01, 32'h999, 1);
      trap = 0;
      chk("coll_mepc", mepc, 32'h800);
      chk("coll_rdata", rdata, 32'h400);
      chk("coll_valid", {31'b0, rsp_valid}, 32'h1);
      tick();
      rsp_ready = 0;
      issue(12'h7C0, 2'b01, 32'hFFFF, 1);
      for (int k = 0; k < 3; k++) begin
         chk("ill_flag", {31'b0, illegal}, 32'h1);
         chk("ill_rdata", rdata, 32'h0);
         chk("ill_ready", {31'b0, req_ready}, 32'h0);
         tick();
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      issue(12'h305, 2'b01, 32'h1000, 1);
      chk("pre_rst_mtvec", mtvec, 32'h1000);
      rst_n = 0;
      #1;
      chk("rst_mid_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_mid_mtvec", mtvec, 32'h80);
      chk("rst_mid_mepc", mepc, 32'h0);
      tick();
      rst_n = 1;
      rsp_ready = 1;
      tick();

      for (int n = 0; n < 3000; n++) begin
         logic [11:0] lst [5];
         lst = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
         req_valid = ($urandom_range(0, 3) != 0);
         addr      = ($urandom_range(0, 7) == 0) ? 12'($urandom) : lst[$urandom_range(0, 4)];
         op        = 2'($urandom);
         wdata     = $urandom;
         if (addr == 12'h305) wdata[1:0] = 2'b00;
         we        = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         trap      = ($urandom_range(0, 9) == 0);
         trap_pc   = $urandom;
         cause     = 6'($urandom);
         mret      = ($urandom_range(0, 7) == 0);
         rst_n     = ($urandom_range(0, 299) != 0);
         tick();
      end
      idle_in();
      rst_n = 1;
      tick();
      tick();
      check_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
